multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small RISC-V subset (R add/sub/and/or, LD, SD, BEQ).
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
// Most outputs come straight from registers. The combinational outputs are
// ir_write (imem_ack), pc_src (zero) and the store-completion pc_write (dmem_ack).
// The store's final cycle is the dmem_ack cycle, so that is the only cycle in
// which its PC update can fall.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b30,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [3:0]       alu_cnt,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {C_R, C_LD, C_SD, C_BEQ} cls_t;

    localparam logic [6:0]       OP_R    = 7'b0110011;
    localparam logic [6:0]       OP_LD   = 7'b0000011;
    localparam logic [6:0]       OP_SD   = 7'b0100011;
    localparam logic [6:0]       OP_BEQ  = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     st;
    cls_t       cls;
    logic       pc_write_q;

    logic       dec_legal;
    cls_t       dec_cls;
    logic [3:0] dec_alu;
    logic       dec_src;

    // Instruction decode; only sampled into registers in DECODE.
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        dec_alu   = 4'b0010;
        dec_src   = 1'b0;
        case (opcode)
            OP_R: begin
                case ({funct3, funct7b30})
                    4'b0000: dec_alu = 4'b0010;
                    4'b0001: dec_alu = 4'b0110;
                    4'b1110: dec_alu = 4'b0000;
                    4'b1100: dec_alu = 4'b0001;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LD: begin
                dec_cls = C_LD;
                dec_src = 1'b1;
            end
            OP_SD: begin
                dec_cls = C_SD;
                dec_src = 1'b1;
            end
            OP_BEQ: begin
                dec_cls = C_BEQ;
                dec_alu = 4'b0110;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Main FSM: next state plus registered strobes for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= S_FETCH;
            cls         <= C_R;
            imem_req    <= 1'b0;
            pc_write_q  <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            alu_src     <= 1'b0;
            alu_cnt     <= 4'b0000;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            // single-cycle strobes drop unless the next state re-asserts them
            pc_write_q <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            case (st)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && imem_ack) begin
                        imem_req <= 1'b0;
                        st       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        cls        <= dec_cls;
                        alu_cnt    <= dec_alu;
                        alu_src    <= dec_src;
                        pc_write_q <= (dec_cls == C_BEQ);
                        st         <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        st      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_R: begin
                            reg_write  <= 1'b1;
                            pc_write_q <= 1'b1;
                            st         <= S_WB;
                        end
                        C_LD: begin
                            mem_read <= 1'b1;
                            st       <= S_MEM;
                        end
                        C_SD: begin
                            mem_write <= 1'b1;
                            st        <= S_MEM;
                        end
                        default: begin
                            imem_req    <= 1'b1;
                            instr_count <= instr_count + CNT_ONE;
                            st          <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (cls == C_LD) begin
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                            pc_write_q <= 1'b1;
                            st         <= S_WB;
                        end else begin
                            imem_req    <= 1'b1;
                            instr_count <= instr_count + CNT_ONE;
                            st          <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    imem_req    <= 1'b1;
                    instr_count <= instr_count + CNT_ONE;
                    st          <= S_FETCH;
                end
                default: begin
                    // TRAP and the unused encodings: everything quiet until reset
                    imem_req  <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    st        <= S_TRAP;
                end
            endcase
        end
    end

    assign state    = st;
    assign ir_write = (st == S_FETCH) && imem_req && imem_ack;
    assign pc_src   = (st == S_EXEC) && (cls == C_BEQ) && zero;
    assign pc_write = pc_write_q || ((st == S_MEM) && (cls == C_SD) && dmem_ack);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected-trace model plus
// literal spot checks on latency, counter and reset values.
module tb_multicycle_control;

    localparam int CW = 4;

    typedef struct packed {
        logic [2:0]    state;
        logic          imem_req;
        logic          ir_write;
        logic          pc_write;
        logic          pc_src;
        logic          alu_src;
        logic [3:0]    alu_cnt;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          illegal;
        logic [CW-1:0] cnt;
    } outs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7b30 = 1'b0;
    logic          zero = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [3:0]    alu_cnt;
    logic          reg_write, mem_read, mem_write, mem_to_reg;
    logic [2:0]    state;
    logic          illegal;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7b30(funct7b30), .zero(zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_cnt(alu_cnt), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    outs_t got_o, exp_o;
    logic  chk_en = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc_n = 0;
    int    rd_hi = 0;

    // model state: what the spec says is architecturally visible
    int         m_cnt = 0;
    logic [3:0] m_alu = '0;
    logic       m_src = 1'b0;
    logic       m_ill = 1'b0;

    always_comb begin
        got_o            = '0;
        got_o.state      = state;
        got_o.imem_req   = imem_req;
        got_o.ir_write   = ir_write;
        got_o.pc_write   = pc_write;
        got_o.pc_src     = pc_src;
        got_o.alu_src    = alu_src;
        got_o.alu_cnt    = alu_cnt;
        got_o.reg_write  = reg_write;
        got_o.mem_read   = mem_read;
        got_o.mem_write  = mem_write;
        got_o.mem_to_reg = mem_to_reg;
        got_o.illegal    = illegal;
        got_o.cnt        = instr_count;
    end

    function automatic string fmt(input outs_t o);
        return $sformatf("st=%0d req=%b ir=%b pcw=%b pcs=%b src=%b alu=%b rw=%b mr=%b mw=%b m2r=%b ill=%b cnt=%0d",
                         o.state, o.imem_req, o.ir_write, o.pc_write, o.pc_src, o.alu_src, o.alu_cnt,
                         o.reg_write, o.mem_read, o.mem_write, o.mem_to_reg, o.illegal, o.cnt);
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && mem_read) rd_hi++;
        if (chk_en) begin
            n_checks++;
            if (got_o !== exp_o) begin
                n_errors++;
                $display("FAIL cycle_%0d got %s expected %s", cyc_n, fmt(got_o), fmt(exp_o));
            end
        end
    end

    task automatic lit(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic outs_t base(input logic [2:0] s);
        outs_t o;
        o         = '0;
        o.state   = s;
        o.alu_cnt = m_alu;
        o.alu_src = m_src;
        o.illegal = m_ill;
        o.cnt     = CW'(m_cnt);
        return o;
    endfunction

    // One clock cycle: apply acks, publish expectation, advance to posedge+1.
    task automatic step(input outs_t e, input logic ia, input logic da);
        imem_ack = ia;
        dmem_ack = da;
        exp_o    = e;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Expected trace of one instruction built from its class and the memory waits.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic b30,
                             input logic z, input int iw, input int dw, input bit abort_mem,
                             output int cycles);
        outs_t      e;
        int         c0, k;
        logic       legal;
        logic [3:0] alu;
        logic       src;
        c0 = cyc_n;
        opcode = op; funct3 = f3; funct7b30 = b30; zero = z;
        legal = 1'b1; k = 0; alu = 4'b0010; src = 1'b0;
        case (op)
            7'b0110011: begin
                if      ({f3, b30} == 4'b0000) alu = 4'b0010;
                else if ({f3, b30} == 4'b0001) alu = 4'b0110;
                else if ({f3, b30} == 4'b1110) alu = 4'b0000;
                else if ({f3, b30} == 4'b1100) alu = 4'b0001;
                else legal = 1'b0;
            end
            7'b0000011: begin k = 1; src = 1'b1; end
            7'b0100011: begin k = 2; src = 1'b1; end
            7'b1100011: begin k = 3; alu = 4'b0110; end
            default:    legal = 1'b0;
        endcase
        for (int i = 0; i < iw; i++) begin
            e = base(3'd0); e.imem_req = 1'b1; step(e, 1'b0, 1'b1);
        end
        e = base(3'd0); e.imem_req = 1'b1; e.ir_write = 1'b1; step(e, 1'b1, 1'b1);
        e = base(3'd1); step(e, 1'b1, 1'b1);
        if (!legal) begin
            m_ill = 1'b1;
            for (int i = 0; i < 20; i++) begin
                e = base(3'd7); step(e, 1'b1, 1'b1);
            end
        end else begin
            m_alu = alu; m_src = src;
            e = base(3'd2);
            if (k == 3) begin
                e.pc_write = 1'b1; e.pc_src = z; step(e, 1'b1, 1'b1);
                m_cnt = (m_cnt + 1) % (1 << CW);
            end else begin
                step(e, 1'b1, 1'b1);
                if (k == 0) begin
                    e = base(3'd4); e.reg_write = 1'b1; e.pc_write = 1'b1; step(e, 1'b1, 1'b1);
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end else begin
                    for (int i = 0; i < dw; i++) begin
                        e = base(3'd3); e.mem_read = (k == 1); e.mem_write = (k == 2);
                        step(e, 1'b1, 1'b0);
                    end
                    if (!abort_mem) begin
                        e = base(3'd3); e.mem_read = (k == 1); e.mem_write = (k == 2);
                        e.pc_write = (k == 2); step(e, 1'b1, 1'b1);
                        if (k == 1) begin
                            e = base(3'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                            e.pc_write = 1'b1; step(e, 1'b1, 1'b1);
                        end
                        m_cnt = (m_cnt + 1) % (1 << CW);
                    end
                end
            end
        end
        cycles = cyc_n - c0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        chk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        lit("rst_state", int'(state), 0);
        lit("rst_strobes", int'({imem_req, ir_write, pc_write, pc_src, reg_write,
                                 mem_read, mem_write, mem_to_reg}), 0);
        lit("rst_alu", int'({alu_src, alu_cnt}), 0);
        lit("rst_illegal", int'(illegal), 0);
        lit("rst_count", int'(instr_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_cnt = 0; m_alu = '0; m_src = 1'b0; m_ill = 1'b0;
    endtask

    initial begin
        int c, rd_base;
        #1;
        do_reset();
        lit("req_after_reset", int'(imem_req), 1);

        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);   // add
        lit("add_latency", c, 4);
        lit("add_count", int'(instr_count), 1);
        lit("add_alu", int'(alu_cnt), 2);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b1, 2, 0, 1'b0, c);   // sub, zero=1 ignored
        lit("sub_latency", c, 6);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b1, 0, 0, 1'b0, c);   // and
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 1, 0, 1'b0, c);   // or

        rd_base = rd_hi;
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0, c);   // ld, 3 waits
        lit("ld_latency", c, 8);
        lit("ld_read_cycles", rd_hi - rd_base, 4);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, c);   // sd
        lit("sd_latency", c, 4);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b1, 0, 2, 1'b0, c);   // sd, 2 waits
        lit("sd_wait_latency", c, 6);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, c);   // beq taken
        lit("beq_latency", c, 3);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);   // beq not taken
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, c);   // ld, no wait
        lit("ld_fast_latency", c, 5);
        lit("count_before_trap", int'(instr_count), 10);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);   // illegal opcode
        lit("trap_illegal", int'(illegal), 1);
        do_reset();
        lit("trap_exit_state", int'(state), 0);
        run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0, c);   // illegal funct
        do_reset();

        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 5, 1'b1, c);   // sd aborted in MEM
        lit("abort_pre_mem_write", int'(mem_write), 1);
        lit("abort_pre_count", int'(instr_count), 2);
        do_reset();

        for (int i = 0; i < 17; i++)
            run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, c);
        lit("wrap_count", int'(instr_count), 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
